// File: rtl/audio_jitter_buffer.sv
// ============================================================================
// AudioJitterBuffer (top module audio_jitter_buffer)
//
// Purpose:
//    Smooths bursty audio bytes arriving from the packet splitter into a
//    steady stream of 8-bit samples, one per TICK_DIV clock cycles. Bytes
//    land in a DEPTH-entry FIFO. Playback starts once PREFILL bytes are
//    buffered. When the buffer runs dry, playback falls back to filling.
//
// Parameters:
//    DEPTH     FIFO entries, power of two, 4..1024
//    PREFILL   fill level needed before playback starts, 1..DEPTH
//    TICK_DIV  clock cycles per output sample, minimum 2
//
// Ports:
//    clk           system clock (50 MHz RMII domain)
//    rst           synchronous active-high reset
//    axiiv         audio byte valid (no backpressure upstream)
//    axiid         audio byte, unsigned PCM
//    sample_out    current playback sample, held between ticks
//    sample_valid  one-cycle pulse when sample_out is updated
//    level         current FIFO occupancy
//    playing       high while in PLAY state
//    overflow      sticky, a byte was dropped because the FIFO was full
//    underflow     sticky, a tick found the FIFO empty during playback
//    pwm_out       1-bit PWM audio output
//
// Configuration:
//    AUDIO_PWM_EN  when defined, a free-running 8-bit PWM counter drives
//                  pwm_out. When undefined, pwm_out is tied low.
// ============================================================================
module audio_jitter_buffer #(
   parameter int DEPTH    = 256,
   parameter int PREFILL  = 128,
   parameter int TICK_DIV = 6250
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     axiiv,
   input  logic [7:0]               axiid,
   output logic [7:0]               sample_out,
   output logic                     sample_valid,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     playing,
   output logic                     overflow,
   output logic                     underflow,
   output logic                     pwm_out
);

   localparam int PW = $clog2(DEPTH);
   localparam int LW = PW + 1;
   localparam int TW = $clog2(TICK_DIV);

   typedef enum logic {
      FILL = 1'b0,
      PLAY = 1'b1
   } state_t;

   state_t          r_state;
   state_t          w_stateNext;
   logic [PW-1:0]   r_wrPtr;
   logic [PW-1:0]   r_rdPtr;
   logic [LW-1:0]   r_level;
   logic [TW-1:0]   r_tickCnt;
   logic [7:0]      r_sampleOut;
   logic            r_sampleValid;
   logic            r_overflow;
   logic            r_underflow;
   logic [7:0]      r_mem [DEPTH];

   logic            w_tick;
   logic            w_full;
   logic            w_pop;
   logic            w_underrun;
   logic            w_write;
   logic            w_drop;

   // Decode the cycle's events from the current registered state.
   // A pop frees a slot in the same cycle, so a full FIFO still accepts a
   // write when the tick pops. A byte is dropped only when the FIFO is full
   // and nothing is popped. Leaving PLAY happens only on a tick that finds
   // the FIFO empty. Entering PLAY uses the registered level, so playing
   // rises on the cycle after the level reaches PREFILL.
   always_comb begin
      w_tick      = (r_tickCnt == TW'(TICK_DIV - 1));
      w_full      = (r_level == LW'(DEPTH));
      w_pop       = 1'b0;
      w_underrun  = 1'b0;
      w_write     = 1'b0;
      w_drop      = 1'b0;
      w_stateNext = r_state;

      if (r_state == PLAY && w_tick) begin
         if (r_level != '0) begin
            w_pop = 1'b1;
         end else begin
            w_underrun = 1'b1;
         end
      end

      if (axiiv) begin
         if (!w_full || w_pop) begin
            w_write = 1'b1;
         end else begin
            w_drop = 1'b1;
         end
      end

      case (r_state)
         FILL: begin
            if (r_level >= LW'(PREFILL)) begin
               w_stateNext = PLAY;
            end
         end
         PLAY: begin
            if (w_underrun) begin
               w_stateNext = FILL;
            end
         end
         default: w_stateNext = FILL;
      endcase
   end

   // FIFO storage is a plain write port with no reset, so the tools can map
   // it onto a simple dual-port block RAM. Stale contents after a reset do
   // no harm because the pointers and level are cleared.
   always_ff @(posedge clk) begin
      if (w_write) begin
         r_mem[r_wrPtr] <= axiid;
      end
   end

   // Control registers. The read port is registered straight into
   // sample_out, so a sample appears exactly one cycle after its tick. The
   // pointers wrap for free because DEPTH is a power of two. The level
   // tracks writes minus pops and stays put when both happen together.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= FILL;
         r_wrPtr       <= '0;
         r_rdPtr       <= '0;
         r_level       <= '0;
         r_tickCnt     <= '0;
         r_sampleOut   <= 8'h80;
         r_sampleValid <= 1'b0;
         r_overflow    <= 1'b0;
         r_underflow   <= 1'b0;
      end else begin
         r_state       <= w_stateNext;
         r_tickCnt     <= w_tick ? '0 : r_tickCnt + TW'(1);
         r_sampleValid <= w_pop | w_underrun;

         if (w_pop) begin
            r_sampleOut <= r_mem[r_rdPtr];
            r_rdPtr     <= r_rdPtr + PW'(1);
         end else if (w_underrun) begin
            r_sampleOut <= 8'h80;
         end

         if (w_write) begin
            r_wrPtr <= r_wrPtr + PW'(1);
         end

         case ({w_write, w_pop})
            2'b10:   r_level <= r_level + LW'(1);
            2'b01:   r_level <= r_level - LW'(1);
            default: r_level <= r_level;
         endcase

         if (w_drop) begin
            r_overflow <= 1'b1;
         end
         if (w_underrun) begin
            r_underflow <= 1'b1;
         end
      end
   end

`ifdef AUDIO_PWM_EN
   logic [7:0] r_pwmCnt;
   logic       r_pwmOut;

   // Free-running 8-bit PWM with a 256-cycle period. The duty cycle equals
   // sample_out/256, and the output is registered to keep it glitch-free.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_pwmCnt <= '0;
         r_pwmOut <= 1'b0;
      end else begin
         r_pwmCnt <= r_pwmCnt + 8'd1;
         r_pwmOut <= (r_pwmCnt < r_sampleOut);
      end
   end

   assign pwm_out = r_pwmOut;
`else
   // PWM is disabled in this build, so the output is tied low.
   assign pwm_out = 1'b0;
`endif

   // Drive the outputs from their registers.
   assign sample_out   = r_sampleOut;
   assign sample_valid = r_sampleValid;
   assign level        = r_level;
   assign playing      = (r_state == PLAY);
   assign overflow     = r_overflow;
   assign underflow    = r_underflow;

endmodule
